// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module seq_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [2*N-1:0] dividend_in,
  input  logic [N-1:0]   divisor_in,
  output logic           busy,
  output logic           done,
  output logic           div_zero,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder
);

  localparam int CW = $clog2(2*N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [2*N-1:0] dividend_sr;
  logic [N-1:0]   divisor_q;
  logic [N:0]     partial_rem;
  logic [2*N-1:0] quot_q;
  logic [CW-1:0]  count;
  logic           div_zero_q;

  // Trial subtract: the extra MSB of trial only exists so the compare can see
  // the bit shifted out of the partial remainder.
  logic [N:0] trial;
  logic [N:0] diff;
  logic       ge;

  // NOTE: every signal driven here gets a value on every path, so no latches.
  always_comb begin
    trial = {partial_rem[N-1:0], dividend_sr[2*N-1]};
    diff  = trial - {1'b0, divisor_q};
    ge    = (trial >= {1'b0, divisor_q});
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      dividend_sr <= '0;
      divisor_q   <= '0;
      partial_rem <= '0;
      quot_q      <= '0;
      count       <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend_sr <= dividend_in;
            divisor_q   <= divisor_in;
            count       <= CW'(2*N);
            div_zero_q  <= (divisor_in == '0);
            if (divisor_in == '0) begin
              // Divide by zero: result is fixed, no iterations run.
              quot_q      <= '1;
              partial_rem <= {1'b0, dividend_in[N-1:0]};
              state       <= DONE;
            end else begin
              quot_q      <= '0;
              partial_rem <= '0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          dividend_sr <= {dividend_sr[2*N-2:0], 1'b0};
          partial_rem <= ge ? diff : trial;
          quot_q      <= {quot_q[2*N-2:0], ge};
          count       <= count - CW'(1);
          if (count == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign div_zero  = div_zero_q;
  assign quotient  = quot_q;
  assign remainder = partial_rem[N-1:0];

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): scoreboard of expected results,
// pushed when an operation is started and popped when done is seen.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int N      = 4;
  localparam int PERIOD = 10;

  logic           clk;
  logic           clr;
  logic           start;
  logic [2*N-1:0] dividend_in;
  logic [N-1:0]   divisor_in;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;

  typedef struct {
    logic [2*N-1:0] dvd;
    logic [N-1:0]   dvs;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  time  t_accept;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts one operation at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_op(input logic [2*N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_start: busy=%b expected 0", busy);
    end
    e.dvd = a;
    e.dvs = b;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a[N-1:0];
      e.dz = 1'b1;
    end else begin
      e.q  = a / {4'b0, b};
      e.r  = 4'(a % {4'b0, b});
      e.dz = 1'b0;
    end
    sb.push_back(e);
    dividend_in = a;
    divisor_in  = b;
    start       = 1'b1;
    @(posedge clk);
    t_accept = $time;
    @(negedge clk);
    start       = 1'b0;
    dividend_in = 8'($urandom);
    divisor_in  = 4'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: busy=%b expected 1", busy);
    end
  endtask

  // Waits (bounded) for done, pops the scoreboard and compares; returns one cycle after done.
  task automatic collect_result();
    exp_t e;
    int   cyc = 0;
    int   edges;
    int   exp_edges;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry for result");
      return;
    end
    e = sb.pop_front();
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, cyc);
      return;
    end
    edges     = int'(($time - PERIOD/2 - t_accept) / PERIOD) + 1;
    exp_edges = e.dz ? 1 : 2*N + 1;
    checks++;
    if (edges !== exp_edges) begin
      errors++;
      $display("FAIL latency %0d/%0d: edges=%0d expected %0d", e.dvd, e.dvs, edges, exp_edges);
    end
    checks++;
    if (quotient !== e.q) begin
      errors++;
      $display("FAIL quotient %0d/%0d: got %0d expected %0d", e.dvd, e.dvs, quotient, e.q);
    end
    checks++;
    if (remainder !== e.r) begin
      errors++;
      $display("FAIL remainder %0d/%0d: got %0d expected %0d", e.dvd, e.dvs, remainder, e.r);
    end
    checks++;
    if (div_zero !== e.dz || busy !== 1'b1) begin
      errors++;
      $display("FAIL flags_in_done %0d/%0d: div_zero=%b busy=%b expected %b 1",
               e.dvd, e.dvs, div_zero, busy, e.dz);
    end
    if (!e.dz) begin
      checks++;
      if (int'(quotient) * int'(e.dvs) + int'(remainder) != int'(e.dvd) || remainder >= e.dvs) begin
        errors++;
        $display("FAIL invariant %0d/%0d: q=%0d r=%0d", e.dvd, e.dvs, quotient, remainder);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
      errors++;
      $display("FAIL after_done %0d/%0d: done=%b busy=%b q=%0d r=%0d dz=%b expected 0 0 %0d %0d %b",
               e.dvd, e.dvs, done, busy, quotient, remainder, div_zero, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    start = 1'b0;
    dividend_in = '0;
    divisor_in = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b q=%0d r=%0d expected all 0",
               busy, done, div_zero, quotient, remainder);
    end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    drive_op(8'd6, 4'd2);     collect_result();
    drive_op(8'd200, 4'd15);  collect_result();
    drive_op(8'd255, 4'd1);   collect_result();
    drive_op(8'd7, 4'd9);     collect_result();
  endtask

  task automatic test_div_zero();
    drive_op(8'hA7, 4'd0);
    collect_result();
    // Follow with a normal divide so div_zero must fall on the next acceptance.
    drive_op(8'd100, 4'd7);
    collect_result();
  endtask

  task automatic test_ignore_start();
    drive_op(8'd200, 4'd15);
    repeat (3) @(negedge clk);
    start       = 1'b1;
    dividend_in = 8'h55;
    divisor_in  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    collect_result();
    repeat (5) @(negedge clk);
    checks++;
    if (quotient !== 8'd13 || remainder !== 4'd5 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_done: q=%0d r=%0d busy=%b done=%b expected 13 5 0 0",
               quotient, remainder, busy, done);
    end
  endtask

  task automatic test_clr_abort();
    exp_t dropped;
    bit   seen_done = 1'b0;
    drive_op(8'd200, 4'd15);
    repeat (4) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL clr_midrun: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
               busy, done, quotient, remainder, div_zero);
    end
    if (sb.size() != 0) dropped = sb.pop_front();
    @(negedge clk);
    clr = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL aborted_op_activity: done/busy seen=%b expected 0", seen_done);
    end
    drive_op(8'd6, 4'd2);
    collect_result();
  endtask

  task automatic test_sweep();
    for (int d = 1; d < 16; d++) begin
      for (int a = 0; a < 256; a++) begin
        drive_op(8'(a), 4'(d));
        collect_result();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_clr_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
